fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch queue between the fetch stage (instruction unit + itcm read data) and the execution stage. Buffers up to DEPTH fetched {pc, instruction} pairs, so a one-cycle execution hazard no longer back-pressures the itcm address path combinationally. All contents are discarded on a branch/jump redirect from execution. It is a synchronous FIFO with registered storage, full/empty tracking and flush.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- CW, $clog2(DEPTH+1), width of the occupancy count

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears pointers and count
- flush  in  1  redirect from execution (driven by pc_v_x); empties queue this edge
- in_v  in  1  fetch presents a valid pair this cycle
- in_pc  in  32  pc of fetched instruction
- in_inst  in  32  itcm read data for in_pc
- in_rdy  out  1  queue can accept; fetch holds its request when low (drives stall_i)
- out_v  out  1  head entry valid
- out_pc  out  32  head pc; 0 when out_v=0
- out_inst  out  32  head instruction; 0 when out_v=0
- out_rdy  in  1  execution consumes head this cycle (= !hazard_x)
- count  out  CW  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry array of {pc[31:0], inst[31:0]}. Not reset; contents never observable while out_v=0.
- Pointers wr_ptr, rd_ptr, log2(DEPTH) bits each; increment modulo DEPTH (natural wrap). count kept as a separate CW-bit register.
- in_rdy = (count != DEPTH); purely from registered count, with no combinational path from out_rdy.
- out_v = (count != 0); out_pc/out_inst = array[rd_ptr] gated to 0 when out_v=0.
- push = in_v & in_rdy & !flush: write array[wr_ptr], wr_ptr+1.
- pop = out_v & out_rdy & !flush: rd_ptr+1.
- count_next: push&!pop → +1; pop&!push → −1; both or neither → unchanged.
- flush (has priority over everything): wr_ptr=0, rd_ptr=0, count=0; concurrent in_v ignored (fetch re-issues from redirect target next cycle); concurrent out_rdy consumes nothing.
- No bypass: an entry pushed at edge N is first visible on out_* after edge N.
- in_v while in_rdy=0: not accepted; fetch must hold in_pc/in_inst stable until accepted.
- When full, a simultaneous pop does not enable a push in the same cycle (in_rdy already 0); the push happens the following cycle.
- Flush is level-sensitive: while held high, the queue stays empty and in_rdy=1.

## Timing
- Reset (async assert, sync release by enclosing logic): count=0, wr_ptr=rd_ptr=0, out_v=0, out_pc=0, out_inst=0, in_rdy=1, all in the same cycle as assertion, with no clock needed.
- Fill latency: in_v at cycle 0 → out_v=1 in cycle 1.
- Throughput: 1 push + 1 pop per cycle sustained when 0 < count < DEPTH.
- Full: count=DEPTH → in_rdy=0 in the same cycle; first pop edge → in_rdy=1 next cycle.
- Empty: last pop at edge N → out_v=0 after N unless a push occurred at N.
- Flush at edge N → out_v=0, count=0, in_rdy=1 from cycle N+1; push at N+1 visible at N+2.
- Reset mid-operation: pending entries lost, identical to flush but asynchronous.

## Test plan
- Reset: assert reset mid-stream with count=3 → out_v=0, count=0, in_rdy=1 immediately; next push pc=0x100 appears on out_* one cycle later.
- Ordering/wrap: DEPTH=4, out_rdy=1, push pc 0x0,0x4,…,0x3C (16 consecutive) → out_pc sequence identical, 1-cycle lag, count stays 1, pointers wrap 4 times.
- Full: out_rdy=0, push 5 pairs → count=4, in_rdy=0, fifth held; raise out_rdy one cycle → head 0x0 popped, fifth accepted next cycle, count returns to 4.
- Simultaneous: count=2, in_v=1 & out_rdy=1 for 3 cycles → count stays 2, out_pc advances each cycle.
- Flush: count=3, flush=1 with in_v=1 (pc=0x200) and out_rdy=1 → next cycle count=0, out_v=0, 0x200 not stored; push 0x300 → out_pc=0x300 one cycle later.
- Empty pop: count=0, out_rdy=1 for 5 cycles → count stays 0, rd_ptr unchanged, out_pc=out_inst=0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and execute: DEPTH-entry {pc, inst} FIFO
// with registered occupancy count and a flush that has priority over push and pop.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_v,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst,
  output logic          in_rdy,
  output logic          out_v,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  input  logic          out_rdy,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  // in_rdy depends only on the registered count, keeping out_rdy off the fetch path
  assign in_rdy = (count_q != CW'(DEPTH));
  assign out_v  = (count_q != '0);
  assign count  = count_q;

  assign push = in_v & in_rdy & ~flush;
  assign pop  = out_v & out_rdy & ~flush;

  assign out_pc   = out_v ? pc_mem[rd_ptr]   : '0;
  assign out_inst = out_v ? inst_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4): ordering/wrap, full, simultaneous
// push/pop, flush, empty pop and asynchronous reset, checked with immediate assertions.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_v;
  logic [31:0]   in_pc;
  logic [31:0]   in_inst;
  logic          in_rdy;
  logic          out_v;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_rdy;
  logic [CW-1:0] count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_v(in_v), .in_pc(in_pc), .in_inst(in_inst), .in_rdy(in_rdy),
    .out_v(out_v), .out_pc(out_pc), .out_inst(out_inst), .out_rdy(out_rdy),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the head entry and occupancy together.
  task automatic chk_head(input string tag, input logic v, input logic [31:0] pc,
                          input int unsigned cnt);
    chk({tag, ".out_v"}, 32'(out_v), 32'(v));
    chk({tag, ".out_pc"}, out_pc, v ? pc : 32'h0);
    chk({tag, ".out_inst"}, out_inst, v ? inst_of(pc) : 32'h0);
    chk({tag, ".count"}, 32'(count), 32'(cnt));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    in_v    = v;
    in_pc   = pc;
    in_inst = inst_of(pc);
    out_rdy = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #1;
    chk_head("reset0", 1'b0, 32'h0, 0);
    chk("reset0.in_rdy", 32'(in_rdy), 32'd1);
    tick;
    tick;
    reset = 1'b0;

    // Ordering and pointer wrap: 16 pushes with out_rdy held high
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(i * 4), 1'b1);
      tick;
      chk_head($sformatf("stream%0d", i), 1'b1, 32'(i * 4), 1);
    end
    drive(1'b0, 32'h0, 1'b1);
    tick;
    chk_head("stream_drain", 1'b0, 32'h0, 0);

    // Full: four accepted, fifth held until a pop frees a slot
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0);
      tick;
    end
    chk_head("full", 1'b1, 32'h0, 4);
    chk("full.in_rdy", 32'(in_rdy), 32'd0);
    drive(1'b1, 32'h10, 1'b0);
    tick;
    chk_head("full_hold", 1'b1, 32'h0, 4);
    chk("full_hold.in_rdy", 32'(in_rdy), 32'd0);
    drive(1'b1, 32'h10, 1'b1);
    tick;
    chk_head("full_pop", 1'b1, 32'h4, 3);
    chk("full_pop.in_rdy", 32'(in_rdy), 32'd1);
    drive(1'b1, 32'h10, 1'b0);
    tick;
    chk_head("full_refill", 1'b1, 32'h4, 4);
    drive(1'b0, 32'h0, 1'b1);
    tick;
    chk_head("full_d1", 1'b1, 32'h8, 3);
    tick;
    chk_head("full_d2", 1'b1, 32'hC, 2);
    tick;
    chk_head("full_d3", 1'b1, 32'h10, 1);
    tick;
    chk_head("full_d4", 1'b0, 32'h0, 0);

    // Simultaneous push and pop at count=2
    drive(1'b1, 32'h40, 1'b0);
    tick;
    drive(1'b1, 32'h44, 1'b0);
    tick;
    chk_head("sim_pre", 1'b1, 32'h40, 2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h48 + i * 4), 1'b1);
      tick;
      chk_head($sformatf("sim%0d", i), 1'b1, 32'(32'h44 + i * 4), 2);
    end

    // Flush with concurrent push and pop at count=3
    drive(1'b1, 32'h54, 1'b0);
    tick;
    chk_head("flush_pre", 1'b1, 32'h4C, 3);
    flush = 1'b1;
    drive(1'b1, 32'h200, 1'b1);
    tick;
    chk_head("flush", 1'b0, 32'h0, 0);
    chk("flush.in_rdy", 32'(in_rdy), 32'd1);
    tick;
    chk_head("flush_held", 1'b0, 32'h0, 0);
    flush = 1'b0;
    drive(1'b1, 32'h300, 1'b0);
    tick;
    chk_head("flush_push", 1'b1, 32'h300, 1);

    // Pops on an empty queue consume nothing
    drive(1'b0, 32'h0, 1'b1);
    tick;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_head($sformatf("empty%0d", i), 1'b0, 32'h0, 0);
    end
    drive(1'b1, 32'h400, 1'b0);
    tick;
    chk_head("empty_push", 1'b1, 32'h400, 1);
    drive(1'b0, 32'h0, 1'b1);
    tick;

    // Asynchronous reset mid-stream at count=3
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h500 + i * 4), 1'b0);
      tick;
    end
    chk_head("rst_pre", 1'b1, 32'h500, 3);
    drive(1'b0, 32'h0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_head("rst_async", 1'b0, 32'h0, 0);
    chk("rst_async.in_rdy", 32'(in_rdy), 32'd1);
    tick;
    reset = 1'b0;
    drive(1'b1, 32'h100, 1'b0);
    tick;
    chk_head("rst_push", 1'b1, 32'h100, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
